// File: rtl/vc_dispatcher.sv
// vc_dispatcher: routes upstream FIFO words to four per-class FIFOs by the top two bits, with head-of-line stall on almost-full.
module vc_dispatcher #(
    parameter int DATA_WIDTH = 12,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  empty_in,
    output logic                  pop_in,
    input  logic                  almost_full_0,
    input  logic                  almost_full_1,
    input  logic                  almost_full_2,
    input  logic                  almost_full_3,
    output logic                  push_0,
    output logic                  push_1,
    output logic                  push_2,
    output logic                  push_3,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic [CNT_WIDTH-1:0]  count_0,
    output logic [CNT_WIDTH-1:0]  count_1,
    output logic [CNT_WIDTH-1:0]  count_2,
    output logic [CNT_WIDTH-1:0]  count_3,
    output logic                  stall
);
    typedef enum logic [1:0] {IDLE, READ, ROUTE, STALL} state_t;
    state_t                state, state_n;
    logic [DATA_WIDTH-1:0] hold_data, hold_n, data_n, word;
    logic [CNT_WIDTH-1:0]  cnt [4];
    logic [3:0]            push, push_n, af_vec;
    logic [1:0]            cls;
    logic                  pop_n, stall_n, deliver;

    assign af_vec = {almost_full_3, almost_full_2, almost_full_1, almost_full_0};
    assign word = (state == STALL) ? hold_data : data_in;
    assign cls = word[DATA_WIDTH-1:DATA_WIDTH-2];
    assign {push_3, push_2, push_1, push_0} = push;
    assign {count_3, count_2, count_1, count_0} = {cnt[3], cnt[2], cnt[1], cnt[0]};

    always_comb begin
        state_n = state;
        pop_n   = 1'b0;
        push_n  = 4'b0;
        stall_n = stall;
        data_n  = data_out;
        hold_n  = hold_data;
        deliver = 1'b0;
        case (state)
            IDLE: begin
                pop_n   = !empty_in;
                state_n = empty_in ? IDLE : READ;
            end
            READ: state_n = ROUTE;
            default: begin
                // Only the addressed destination's flag gates delivery.
                if (!af_vec[cls]) begin
                    deliver = 1'b1;
                    push_n  = 4'b1 << cls;
                    data_n  = word;
                    stall_n = 1'b0;
                    pop_n   = !empty_in;
                    state_n = empty_in ? IDLE : READ;
                end else if (state == ROUTE) begin
                    hold_n  = data_in;
                    stall_n = 1'b1;
                    state_n = STALL;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            pop_in    <= 1'b0;
            push      <= 4'b0;
            stall     <= 1'b0;
            data_out  <= '0;
            hold_data <= '0;
            for (int i = 0; i < 4; i++) cnt[i] <= '0;
        end else begin
            state     <= state_n;
            pop_in    <= pop_n;
            push      <= push_n;
            stall     <= stall_n;
            data_out  <= data_n;
            hold_data <= hold_n;
            if (deliver) cnt[cls] <= cnt[cls] + CNT_WIDTH'(1);
        end
    end
endmodule
